// File: rtl/round_timer_pkg.sv
// Shared constants and state encoding for the round timer and the game FSM.
package round_timer_pkg;

    // Defaults shared with the game FSM
    localparam int DEF_DIV      = 100;
    localparam int DEF_SEC_W    = 7;
    localparam int DEF_WARN_SEC = 5;

    // Round state encoding
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Generalised pulse divider: one registered tick every DIV enabled cycles.
// wrap is the combinational "this enabled cycle completes a unit" flag, so the
// owner can update its own registers on the same edge that raises tick.
module tick_prescaler #(
    parameter int DIV   = 100,
    parameter int DIV_W = $clog2(DIV)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick,
    output logic wrap
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] cnt;

    // A clear in the same cycle discards the wrap
    assign wrap = en & ~clr & (cnt == LAST);

    // Count enabled cycles; clear has priority, count holds while disabled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (en) begin
            cnt  <= (cnt == LAST) ? '0 : cnt + DIV_W'(1);
            tick <= (cnt == LAST);
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/round_timer.sv
// Round timer: prescaled unit ticks drive a loadable per-round countdown.
// Optional warn output is enabled with the ROUND_TIMER_WARN_EN macro.
module round_timer
    import round_timer_pkg::*;
#(
    parameter int DIV      = DEF_DIV,
    parameter int DIV_W    = $clog2(DIV),
    parameter int SEC_W    = DEF_SEC_W,
    parameter int WARN_SEC = DEF_WARN_SEC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    input  logic             tick_en,
    input  logic [SEC_W-1:0] limit,
    output logic [SEC_W-1:0] remaining,
`ifdef ROUND_TIMER_WARN_EN
    output logic             warn,
`endif
    output logic             sec_tick,
    output logic             running,
    output logic             expired
);

    // Catch illegal configurations at elaboration
    if (DIV < 2 || WARN_SEC >= (1 << SEC_W)) begin : g_param_err
        $error("round_timer: DIV must be >= 2 and WARN_SEC must fit in SEC_W");
    end

    state_t           state_q, state_d;
    logic [SEC_W-1:0] rem_q, rem_d;
    logic             exp_d, run_d;
    logic             presc_clr, presc_en, wrap;

    // Start or abort restarts the prescaler; it only counts while truly running
    assign presc_clr = start | abort;
    assign presc_en  = (state_q == ST_RUN) & tick_en & ~pause;

    tick_prescaler #(
        .DIV   (DIV),
        .DIV_W (DIV_W)
    ) u_presc (
        .clk  (clk),
        .rst  (rst),
        .clr  (presc_clr),
        .en   (presc_en),
        .tick (sec_tick),
        .wrap (wrap)
    );

    // Next state and next output values; priority abort > start > pause > tick
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        exp_d   = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
            rem_d   = '0;
        end else if (start) begin
            if (limit != '0) begin
                state_d = ST_RUN;
                rem_d   = limit;
            end else begin
                state_d = ST_EXPIRED;
                rem_d   = '0;
                exp_d   = 1'b1;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (pause) begin
                        state_d = ST_PAUSE;
                    end else if (wrap) begin
                        if (rem_q <= SEC_W'(1)) begin
                            state_d = ST_EXPIRED;
                            rem_d   = '0;
                            exp_d   = 1'b1;
                        end else begin
                            rem_d = rem_q - SEC_W'(1);
                        end
                    end
                end
                ST_PAUSE: begin
                    if (!pause) state_d = ST_RUN;
                end
                default: ;
            endcase
        end
        run_d = (state_d == ST_RUN) || (state_d == ST_PAUSE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            running <= 1'b0;
            expired <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            running <= run_d;
            expired <= exp_d;
        end
    end

    assign remaining = rem_q;

`ifdef ROUND_TIMER_WARN_EN
    // Warn while the round is live and few units remain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) warn <= 1'b0;
        else      warn <= run_d && (rem_d != '0) && (rem_d <= SEC_W'(WARN_SEC));
    end
`endif

endmodule

// File: doc/round_timer.md
Name: round_timer

Overview:
- Parametrised successor of the fixed divide-by-100 pulse counter.
- Generalised prescaler turns qualifying input pulses (tick_en) into a one-cycle unit tick every DIV pulses, then drives a loadable per-round countdown of SEC_W-bit "seconds".
- Sits between the game FSM (start/pause/abort) and the display/score logic (remaining, expired).
- Adds restart, pause, abort, zero-limit handling and an expiry pulse.

Parameters:
- DIV, 100, tick_en pulses per unit tick; legal range is 2 or more.
- DIV_W, $clog2(DIV), prescaler counter width; derived, do not override.
- SEC_W, 7, width of limit and remaining.
- WARN_SEC, 5, warning threshold; used only with the optional feature.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; loads limit and (re)starts the round.
- pause  in  1  level; freezes the countdown while high.
- abort  in  1  one-cycle pulse; cancels the round and returns to IDLE.
- tick_en  in  1  qualifying input pulse; the prescaler counts cycles where this is 1.
- limit  in  SEC_W  round length in units, sampled only on start.
- remaining  out  SEC_W  units left, registered.
- sec_tick  out  1  one-cycle pulse at each unit boundary.
- running  out  1  high in RUN or PAUSE.
- expired  out  1  one-cycle pulse when the round ends.

Behaviour:
- Reset (rst=0, async): state=IDLE, prescaler=0, remaining=0, sec_tick=0, running=0, expired=0. Reset mid-round discards everything, with no expired pulse.
- All outputs are registered. sec_tick and expired are high for exactly one clk.
- Command priority in the same cycle: abort > start > pause > tick_en.
- States:
  - IDLE: running=0.
  - RUN: running=1.
  - PAUSE: running=1.
  - EXPIRED: running=0, remaining=0.
- Any state + abort -> IDLE. remaining<=0 and prescaler<=0; no expired pulse.
- Any state + start (no abort):
  - prescaler<=0.
  - If limit!=0: remaining<=limit, go to RUN. Restart from RUN or PAUSE is legal.
  - If limit==0: go to EXPIRED, expired=1 on the next cycle.
- RUN + pause=1 -> PAUSE. The prescaler and remaining hold, and tick_en is ignored.
- PAUSE + pause=0 -> RUN. The prescaler resumes from its held value.
- Prescaler counting:
  - Counts only in RUN with tick_en=1 and pause=0.
  - When prescaler==DIV-1 with tick_en=1: prescaler<=0 and sec_tick=1 on the next cycle (1-cycle latency).
  - Otherwise prescaler increments and sec_tick=0.
- Countdown: the wrap cycle also decrements remaining in the same edge (remaining updates together with sec_tick).
  - If remaining==1 at the wrap: remaining<=0, go to EXPIRED, and expired=1 alongside the final sec_tick.
- EXPIRED holds until start or abort. tick_en is ignored.
- No wrap-around: remaining never underflows below 0.
- start/abort arriving in the wrap cycle win; the wrap is discarded.

Optional Feature:
- Macro: ROUND_TIMER_WARN_EN.
- Defined: adds output warn (1 bit, registered, reset 0). warn=1 while running=1 and 0 < remaining <= WARN_SEC; it is 0 in all other cases, including PAUSE with remaining > WARN_SEC.
- Undefined: the warn port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package round_timer_pkg:
  - state encoding localparams ST_IDLE, ST_RUN, ST_PAUSE, ST_EXPIRED (2 bits).
  - default DIV/SEC_W constants shared with the game FSM.
- Sub-module tick_prescaler (parameters DIV, DIV_W):
  - Inputs: clk, rst, clr, en.
  - Output: registered tick.
  - This is the generalised pulse divider. round_timer drives clr on start/abort and en = RUN & tick_en & ~pause.

Test Plan (DIV=4, SEC_W=7, tick_en tied 1 unless stated):
- Basic round: start with limit=3 -> sec_tick at 4, 8 and 12 cycles after start. remaining steps 3->2->1->0. expired=1 in the same cycle as the 3rd sec_tick, then running=0.
- Zero limit: start with limit=0 -> next cycle expired=1, state EXPIRED, remaining=0, no sec_tick.
- Pause: start limit=2, 2 tick_en cycles, pause high 10 cycles, release -> first sec_tick 2 enabled cycles after release. remaining holds 2 throughout the pause. running stays 1.
- Restart/abort priority: mid-round with remaining=5, assert start (limit=9) and abort in the same cycle -> IDLE, remaining=0, no expired. Next start limit=9 -> remaining=9 and the prescaler restarts from 0.
- Sparse tick_en: tick_en every 3rd cycle, limit=1 -> expired 12 cycles after start. Async rst=0 mid-round clears all outputs immediately, with no expired pulse.
- Warn (ROUND_TIMER_WARN_EN, WARN_SEC=2): limit=4 -> warn rises with remaining=2 and stays high at 1. It falls when remaining reaches 0, in the cycle expired pulses.
